// File: rtl/ss_display_sched.sv
// ss_display_sched: shares the four-digit seven-segment display between the
// time source and an overlay requester. Every source switch runs fade-out,
// a one-cycle digit swap, then fade-in. All outputs are registered.
//
// Ports:
//   Clk, Reset         clock; synchronous active-high reset
//   TimeBCD            time digits {BCD3,BCD2,BCD1,BCD0}
//   OvlReq / OvlBCD    overlay request (held until OvlAck) and its digits
//   OvlAck             one-cycle pulse; OvlBCD was captured on the edge that raised it
//   TargetBrightness   steady-state brightness
//   BCD3..BCD0         digits to the driver
//   Brightness         brightness to the driver
//   Busy               high while fading or swapping
//
// Optional build macro SS_BLINK_EN: the overlay blinks between
// TargetBrightness and 0 every BLINK_TICKS ticks while it is shown.

module ss_display_sched #(
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned FADE_STEP   = 8,
  parameter int unsigned HOLD_TICKS  = 2000,
  parameter int unsigned BLINK_TICKS = 250
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] TimeBCD,
  input  logic        OvlReq,
  input  logic [15:0] OvlBCD,
  output logic        OvlAck,
  input  logic [7:0]  TargetBrightness,
  output logic [3:0]  BCD3,
  output logic [3:0]  BCD2,
  output logic [3:0]  BCD1,
  output logic [3:0]  BCD0,
  output logic [7:0]  Brightness,
  output logic        Busy
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HoldW = $clog2(HOLD_TICKS + 1);
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_TICKS - 1);
  localparam logic [7:0]       Step    = 8'(FADE_STEP);

  typedef enum logic [2:0] {StShowTime, StFadeOut, StSwap, StFadeIn, StShowOvl} state_e;
  typedef enum logic {SelTime, SelOvl} sel_e;

  state_e            state_q;
  sel_e              sel_q;
  logic [15:0]       disp_q;
  logic [15:0]       ovl_q;
  logic [HoldW-1:0]  hold_cnt_q;
  logic [TickW-1:0]  tick_cnt_q;

  logic       tick;
  logic [8:0] fade_sum;
  logic [7:0] fade_up;
  logic [7:0] fade_dn;
  logic       hold_done;
  logic       req_ok;
  logic [7:0] ovl_bright;

  assign {BCD3, BCD2, BCD1, BCD0} = disp_q;

  // Free-running tick strobe.
  assign tick = (tick_cnt_q == TickMax);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TickW'(1);
    end
  end

  always_comb begin
    fade_sum  = {1'b0, Brightness} + {1'b0, Step};
    fade_up   = (fade_sum > {1'b0, TargetBrightness}) ? TargetBrightness : fade_sum[7:0];
    fade_dn   = (Brightness > Step) ? Brightness - Step : 8'd0;
    hold_done = tick && (hold_cnt_q == HoldMax);
    // Ack is registered, so masking with it keeps a lingering request from
    // producing back-to-back acks.
    req_ok    = OvlReq && !OvlAck;
  end

`ifdef SS_BLINK_EN
  localparam int unsigned BlinkW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_TICKS - 1);

  logic [BlinkW-1:0] blink_cnt_q;
  logic              blink_on_q;
  logic              blink_wrap;
  logic              blink_on_d;

  always_comb begin
    blink_wrap = tick && (blink_cnt_q == BlinkMax);
    blink_on_d = blink_on_q ^ blink_wrap;
    ovl_bright = blink_on_d ? TargetBrightness : 8'd0;
  end

  // Phase is held at "on" outside SHOW_OVL so every entry starts lit, and
  // restarts on each accepted overlay.
  always_ff @(posedge Clk) begin
    if (Reset || state_q != StShowOvl || req_ok) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (tick) begin
      blink_cnt_q <= blink_wrap ? '0 : blink_cnt_q + BlinkW'(1);
      blink_on_q  <= blink_on_d;
    end
  end
`else
  assign ovl_bright = TargetBrightness;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StFadeIn;
      sel_q      <= SelTime;
      disp_q     <= '0;
      ovl_q      <= '0;
      hold_cnt_q <= '0;
      Brightness <= '0;
      OvlAck     <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      OvlAck <= 1'b0;
      unique case (state_q)
        StShowTime: begin
          disp_q     <= TimeBCD;
          Brightness <= TargetBrightness;
          Busy       <= 1'b0;
          if (req_ok) begin
            ovl_q      <= OvlBCD;
            OvlAck     <= 1'b1;
            sel_q      <= SelOvl;
            hold_cnt_q <= '0;
            state_q    <= StFadeOut;
            Busy       <= 1'b1;
          end
        end
        StFadeOut: begin
          Busy <= 1'b1;
          if (Brightness == 8'd0) begin
            state_q <= StSwap;
          end else if (tick) begin
            Brightness <= fade_dn;
          end
        end
        StSwap: begin
          Busy    <= 1'b1;
          disp_q  <= (sel_q == SelOvl) ? ovl_q : TimeBCD;
          state_q <= StFadeIn;
        end
        StFadeIn: begin
          if (Brightness == TargetBrightness) begin
            state_q    <= (sel_q == SelOvl) ? StShowOvl : StShowTime;
            hold_cnt_q <= '0;
            Busy       <= 1'b0;
          end else begin
            Busy <= 1'b1;
            // A lowered target wins over the ramp immediately.
            if (TargetBrightness < Brightness) begin
              Brightness <= TargetBrightness;
            end else if (tick) begin
              Brightness <= fade_up;
            end
          end
        end
        StShowOvl: begin
          Busy   <= 1'b0;
          disp_q <= ovl_q;
          // A new request beats hold expiry: swap digits in place, restart hold.
          if (req_ok) begin
            ovl_q      <= OvlBCD;
            disp_q     <= OvlBCD;
            OvlAck     <= 1'b1;
            hold_cnt_q <= '0;
            Brightness <= TargetBrightness;
          end else if (hold_done) begin
            hold_cnt_q <= '0;
            sel_q      <= SelTime;
            state_q    <= StFadeOut;
            Busy       <= 1'b1;
            Brightness <= ovl_bright;
          end else begin
            Brightness <= ovl_bright;
            if (tick) hold_cnt_q <= hold_cnt_q + HoldW'(1);
          end
        end
        default: begin
          state_q <= StFadeIn;
          Busy    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ss_display_sched.sv
// Bench for ss_display_sched with TICK_DIV=4, FADE_STEP=64, HOLD_TICKS=5.
// Every change of {BCD3..0, Brightness} is popped from an expected-event queue
// that each scenario fills before it drives stimulus.

module tb_ss_display_sched;

  localparam int unsigned TickDiv   = 4;
  localparam int unsigned FadeStep  = 64;
  localparam int unsigned HoldTicks = 5;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] TimeBCD = 16'h1234;
  logic        OvlReq = 1'b0;
  logic [15:0] OvlBCD = 16'h0000;
  logic        OvlAck;
  logic [7:0]  TargetBrightness = 8'hC0;
  logic [3:0]  BCD3, BCD2, BCD1, BCD0;
  logic [7:0]  Brightness;
  logic        Busy;

  ss_display_sched #(
    .TICK_DIV   (TickDiv),
    .FADE_STEP  (FadeStep),
    .HOLD_TICKS (HoldTicks),
    .BLINK_TICKS(3)
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .TimeBCD         (TimeBCD),
    .OvlReq          (OvlReq),
    .OvlBCD          (OvlBCD),
    .OvlAck          (OvlAck),
    .TargetBrightness(TargetBrightness),
    .BCD3            (BCD3),
    .BCD2            (BCD2),
    .BCD1            (BCD1),
    .BCD0            (BCD0),
    .Brightness      (Brightness),
    .Busy            (Busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int acks = 0;
  int cyc = 0;

  logic [23:0] exp_q[$];
  logic [23:0] prev_disp = '0;
  logic [23:0] exp_ev;
  logic        mon_en = 1'b0;
  logic        ack_prev = 1'b0;
  wire  [23:0] cur_disp = {BCD3, BCD2, BCD1, BCD0, Brightness};
  wire  [15:0] cur_bcd  = {BCD3, BCD2, BCD1, BCD0};

  always @(posedge Clk) cyc++;

  // Scoreboard: every display change must match the head of the queue.
  always @(negedge Clk) begin
    if (mon_en && cur_disp !== prev_disp) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL display_unexpected: got bcd=%h bright=%h, required no change",
                 cur_disp[23:8], cur_disp[7:0]);
      end else begin
        exp_ev = exp_q.pop_front();
        if (cur_disp !== exp_ev) begin
          failures++;
          $display("FAIL display_event: got bcd=%h bright=%h, required bcd=%h bright=%h",
                   cur_disp[23:8], cur_disp[7:0], exp_ev[23:8], exp_ev[7:0]);
        end
      end
    end
    prev_disp = cur_disp;
    if (OvlAck === 1'b1) begin
      acks++;
      checks++;
      if (ack_prev) begin
        failures++;
        $display("FAIL ack_pulse: got OvlAck high 2 cycles, required 1");
      end
    end
    ack_prev = (OvlAck === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [15:0] bcd, input logic [7:0] br);
    exp_q.push_back({bcd, br});
  endtask

  task automatic push_fade_out(input logic [15:0] bcd, input logic [7:0] from);
    if (from > 8'h80) push(bcd, 8'h80);
    if (from > 8'h40) push(bcd, 8'h40);
    push(bcd, 8'h00);
  endtask

  task automatic push_fade_in(input logic [15:0] bcd);
    push(bcd, 8'h40);
    push(bcd, 8'h80);
    push(bcd, 8'hC0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: got %0d display events pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic req_overlay(input logic [15:0] bcd, input string name, output int ack_cyc);
    int n = 0;
    @(negedge Clk);
    OvlReq = 1'b1;
    OvlBCD = bcd;
    do begin
      @(negedge Clk);
      n++;
    end while (OvlAck !== 1'b1 && n < 100);
    checks++;
    if (OvlAck !== 1'b1) begin
      failures++;
      $display("FAIL %s_ack: got OvlAck=%b, required 1", name, OvlAck);
    end
    ack_cyc = cyc;
    OvlReq = 1'b0;
    OvlBCD = 16'hEEEE;
  endtask

  task automatic check_idle(input string name, input logic [15:0] bcd);
    repeat (2) @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || cur_bcd !== bcd) begin
      failures++;
      $display("FAIL %s: got Busy=%b bcd=%h, required Busy=0 bcd=%h", name, Busy, cur_bcd, bcd);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if (cur_disp !== 24'h0 || OvlAck !== 1'b0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: got disp=%h ack=%b busy=%b, required disp=000000 ack=0 busy=0",
               cur_disp, OvlAck, Busy);
    end
    push_fade_in(16'h0000);
    push(16'h1234, 8'hC0);
    Reset = 1'b0;
    mon_en = 1'b1;
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_fade_in: got Busy=%b, required 1", Busy);
    end
    wait_drain("reset_fade_in");
    check_idle("reset_show_time", 16'h1234);
  endtask

  task automatic test_overlay();
    int a0 = acks;
    int ac;
    push_fade_out(16'h1234, 8'hC0);
    push(16'hABCD, 8'h00);
    push_fade_in(16'hABCD);
    req_overlay(16'hABCD, "overlay", ac);
    wait_drain("overlay_fade");
    check_idle("overlay_show", 16'hABCD);
    checks++;
    if (acks - a0 != 1) begin
      failures++;
      $display("FAIL overlay_ack_count: got %0d, required 1", acks - a0);
    end
  endtask

  task automatic test_hold();
    int a0 = acks;
    push_fade_out(16'hABCD, 8'hC0);
    push(16'h1234, 8'h00);
    push_fade_in(16'h1234);
    wait_drain("hold_return");
    check_idle("hold_show_time", 16'h1234);
    checks++;
    if (acks != a0) begin
      failures++;
      $display("FAIL hold_ack_count: got %0d, required 0", acks - a0);
    end
  endtask

  task automatic test_req_in_fade();
    int n = 0;
    int ac;
    push_fade_out(16'h1234, 8'hC0);
    push(16'h5678, 8'h00);
    push_fade_in(16'h5678);
    push(16'h0042, 8'hC0);
    req_overlay(16'h5678, "fade_first", ac);
    while (cur_bcd !== 16'h5678 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    OvlReq = 1'b1;
    OvlBCD = 16'h0042;
    n = 0;
    while (OvlAck !== 1'b1 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (OvlAck !== 1'b1 || Busy !== 1'b0 || Brightness !== 8'hC0) begin
      failures++;
      $display("FAIL req_in_fade_ack: got ack=%b busy=%b bright=%h, required ack=1 busy=0 bright=c0",
               OvlAck, Busy, Brightness);
    end
    OvlReq = 1'b0;
    OvlBCD = 16'hEEEE;
    wait_drain("req_in_fade");
  endtask

  task automatic test_back_to_back();
    int ac;
    int n = 0;
    repeat (8) @(negedge Clk);
    push(16'h0099, 8'hC0);
    push_fade_out(16'h0099, 8'hC0);
    push(16'h1234, 8'h00);
    push_fade_in(16'h1234);
    req_overlay(16'h0099, "back_to_back", ac);
    while (Brightness === 8'hC0 && n < 80) begin
      @(negedge Clk);
      n++;
    end
    // Hold restarts at the ack: 5 ticks of 4 cycles, then one more tick to drop.
    checks++;
    if (cyc - ac < 21 || cyc - ac > 24) begin
      failures++;
      $display("FAIL hold_restart: got %0d cycles ack-to-fade, required 21..24", cyc - ac);
    end
    wait_drain("back_to_back");
    check_idle("back_to_back_show", 16'h1234);
  endtask

  task automatic test_target_clamp();
    int ac;
    int n = 0;
    push_fade_out(16'h1234, 8'hC0);
    push(16'h1111, 8'h00);
    push(16'h1111, 8'h40);
    push(16'h1111, 8'h80);
    push(16'h1111, 8'h20);
    req_overlay(16'h1111, "clamp", ac);
    while (!(Brightness === 8'h80 && cur_bcd === 16'h1111) && n < 100) begin
      @(negedge Clk);
      n++;
    end
    TargetBrightness = 8'h20;
    @(negedge Clk);
    checks++;
    if (Brightness !== 8'h20) begin
      failures++;
      $display("FAIL clamp_value: got %h, required 20", Brightness);
    end
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL clamp_advance: got Busy=%b, required 0", Busy);
    end
    push(16'h1111, 8'h00);
    push(16'h1234, 8'h00);
    push(16'h1234, 8'h20);
    wait_drain("clamp_return");
    check_idle("clamp_show_time", 16'h1234);
    push(16'h1234, 8'hC0);
    TargetBrightness = 8'hC0;
    wait_drain("clamp_restore");
  endtask

  task automatic test_reset_mid();
    int ac;
    int n = 0;
    int a0;
    push(16'h1234, 8'h80);
    push(16'h1234, 8'h40);
    push(16'h0000, 8'h00);
    push_fade_in(16'h0000);
    push(16'h1234, 8'hC0);
    req_overlay(16'h7777, "reset_mid", ac);
    while (Brightness !== 8'h40 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    checks++;
    if (cur_disp !== 24'h0 || Busy !== 1'b0 || OvlAck !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_values: got disp=%h busy=%b ack=%b, required disp=000000 busy=0 ack=0",
               cur_disp, Busy, OvlAck);
    end
    wait_drain("reset_mid_fade_in");
    a0 = acks;
    repeat (40) @(negedge Clk);
    checks++;
    if (cur_disp !== 24'h1234C0 || Busy !== 1'b0 || acks != a0) begin
      failures++;
      $display("FAIL reset_mid_overlay_lost: got disp=%h busy=%b acks=%0d, required disp=1234c0 busy=0 acks=0",
               cur_disp, Busy, acks - a0);
    end
  endtask

  initial begin
    test_reset();
    test_overlay();
    test_hold();
    test_req_in_fade();
    test_back_to_back();
    test_target_clamp();
    test_reset_mid();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
